// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU: the 4-bit opcode map, the control
// FSM state encoding and the bit positions of the {Z, N, C, V} flag vector.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

   // Opcode map (unchanged from the combinational ALU, plus MUL and CMP)
   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_LDO = 4'b0001;
   localparam logic [3:0] OP_LDA = 4'b0010;
   localparam logic [3:0] OP_STO = 4'b0011;
   localparam logic [3:0] OP_PRE = 4'b0100;
   localparam logic [3:0] OP_ADD = 4'b0101;
   localparam logic [3:0] OP_LDM = 4'b0110;
   localparam logic [3:0] OP_ADN = 4'b0111;
   localparam logic [3:0] OP_INC = 4'b1000;
   localparam logic [3:0] OP_DEC = 4'b1001;
   localparam logic [3:0] OP_JMP = 4'b1010;
   localparam logic [3:0] OP_CLR = 4'b1011;
   localparam logic [3:0] OP_SUB = 4'b1100;
   localparam logic [3:0] OP_MUL = 4'b1101;
   localparam logic [3:0] OP_CMP = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   // Control FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Bit positions inside the 4-bit flag vector {Z, N, C, V}
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
// Unsigned shift-add multiplier, one partial-product step per cycle.
// The product register starts as {0, multiplier}; each step adds the
// multiplicand to the upper half when the current LSB is set and shifts the
// whole register right by one. After WIDTH steps it holds mcand * mplier.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   load_i         load multiplier, clear product upper half and step counter
//   step_i         perform one shift-add step
//   mcand_i        multiplicand, must stay stable while stepping
//   mplier_i       multiplier, sampled with load_i
//   product_nxt_o  product register value after the current step
//   last_o         the current step is the final (WIDTH-1) one
// -----------------------------------------------------------------------------
module alu_mul_seq #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_i,
   input  logic                 step_i,
   input  logic [WIDTH-1:0]     mcand_i,
   input  logic [WIDTH-1:0]     mplier_i,
   output logic [2*WIDTH-1:0]   product_nxt_o,
   output logic                 last_o
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [2*WIDTH-1:0] prod_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   addend_d;
   logic [WIDTH:0]     sum_d;

   // The step result is exported so the caller can register the finished
   // product in the same edge that performs the final step.
   always_comb begin
      addend_d      = prod_q[0] ? mcand_i : '0;
      sum_d         = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend_d};
      product_nxt_o = {sum_d, prod_q[WIDTH-1:1]};
   end

   assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

   // NOTE: clocked state uses non-blocking (<=) so every flop samples the
   // pre-edge values of the others; blocking here would create order-dependent
   // simulation that disagrees with the synthesized netlist.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q <= '0;
         cnt_q  <= '0;
      end else if (load_i) begin
         prod_q <= {{WIDTH{1'b0}}, mplier_i};
         cnt_q  <= '0;
      end else if (step_i) begin
         prod_q <= product_nxt_o;
         cnt_q  <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Registered WIDTH-bit ALU behind a start/done handshake. Single-cycle ops are
// evaluated on the accepting edge and presented with done in the next cycle;
// MUL is handed to alu_mul_seq and finishes WIDTH cycles later. HLT sets a
// sticky halt that blocks all further starts until reset.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       request, accepted only when idle and not halted
//   op          opcode (OPW bits), sampled with start
//   accum       operand A, sampled with start
//   alu_in      operand B, sampled with start
//   pc_in       NOP source select (1: B, 0: A), sampled with start
//   busy        operation in progress (state != IDLE)
//   done        one-cycle completion pulse
//   alu_out     result, held until the next done
//   alu_out_hi  upper product half for MUL, 0 otherwise
//   flags       {Z, N, C, V}, held until the next done
//   halted      sticky halt, cleared only by reset
// -----------------------------------------------------------------------------
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int OPW   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [OPW-1:0]   op,
   input  logic [WIDTH-1:0] accum,
   input  logic [WIDTH-1:0] alu_in,
   input  logic             pc_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] alu_out,
   output logic [WIDTH-1:0] alu_out_hi,
   output logic [3:0]       flags,
   output logic             halted
);

   localparam int MSB  = WIDTH - 1;
   localparam int HALF = WIDTH / 2;

   state_e             state_q;
   logic               done_q;
   logic               halted_q;
   logic [WIDTH-1:0]   alu_out_q;
   logic [WIDTH-1:0]   alu_out_hi_q;
   logic [3:0]         flags_q;
   logic [WIDTH-1:0]   mcand_q;

   logic               accept;
   logic               is_mul;
   logic [WIDTH-1:0]   add_b;
   logic [WIDTH-1:0]   sub_b;
   logic [WIDTH:0]     sum_w;
   logic [WIDTH:0]     diff_w;
   logic               add_v;
   logic               sub_v;
   logic [WIDTH-1:0]   res_d;
   logic [3:0]         flags_d;
   logic [2*WIDTH-1:0] mul_nxt;
   logic               mul_last;
   logic [3:0]         mul_flags_d;

   assign accept = start && (state_q == ST_IDLE) && !halted_q;
   assign is_mul = (op == OP_MUL);

   alu_mul_seq #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk           (clk),
      .rst_n         (rst_n),
      .load_i        (accept && is_mul),
      .step_i        (state_q == ST_MUL),
      .mcand_i       (mcand_q),
      .mplier_i      (alu_in),
      .product_nxt_o (mul_nxt),
      .last_o        (mul_last)
   );

   // Single-cycle result and flags, computed from the live inputs so they can
   // be registered on the accepting edge.
   always_comb begin
      // NOTE: every variable gets a default at the top of the block so no path
      // leaves it unassigned; an unassigned path would infer a latch.
      add_b   = alu_in;
      sub_b   = alu_in;
      res_d   = accum;
      flags_d = '0;

      if (op == OP_ADN) begin
         add_b = {{(WIDTH - HALF){1'b0}}, alu_in[HALF-1:0]};
      end else if (op == OP_INC) begin
         add_b = WIDTH'(1);
      end
      if (op == OP_DEC) begin
         sub_b = WIDTH'(1);
      end

      sum_w  = {1'b0, accum} + {1'b0, add_b};
      diff_w = {1'b0, accum} - {1'b0, sub_b};
      // Signed overflow: like-signed addends giving an opposite-signed sum,
      // or unlike-signed subtraction whose result sign differs from A.
      add_v  = (accum[MSB] == add_b[MSB]) && (sum_w[MSB]  != accum[MSB]);
      sub_v  = (accum[MSB] != sub_b[MSB]) && (diff_w[MSB] != accum[MSB]);

      case (op)
         OP_NOP:                         res_d = pc_in ? alu_in : accum;
         OP_LDO, OP_LDA, OP_PRE, OP_JMP: res_d = alu_in;
         OP_CLR:                         res_d = '0;
         OP_ADD, OP_ADN, OP_INC: begin
            res_d           = sum_w[MSB:0];
            flags_d[FLAG_C] = sum_w[WIDTH];
            flags_d[FLAG_V] = add_v;
         end
         OP_SUB, OP_DEC, OP_CMP: begin
            res_d           = diff_w[MSB:0];
            flags_d[FLAG_C] = diff_w[WIDTH];
            flags_d[FLAG_V] = sub_v;
         end
         default:                        res_d = accum;
      endcase

      flags_d[FLAG_Z] = (res_d == '0);
      flags_d[FLAG_N] = res_d[MSB];

      // CMP reports flags of A-B but passes A through unchanged.
      if (op == OP_CMP) begin
         flags_d[FLAG_Z] = (accum == alu_in);
         res_d           = accum;
      end

      mul_flags_d         = '0;
      mul_flags_d[FLAG_Z] = (mul_nxt[MSB:0] == '0);
      mul_flags_d[FLAG_N] = mul_nxt[MSB];
      mul_flags_d[FLAG_C] = (mul_nxt[2*WIDTH-1:WIDTH] != '0);
   end

   // Control FSM with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         done_q       <= 1'b0;
         halted_q     <= 1'b0;
         alu_out_q    <= '0;
         alu_out_hi_q <= '0;
         flags_q      <= '0;
         mcand_q      <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  mcand_q <= accum;
                  if (is_mul) begin
                     state_q <= ST_MUL;
                  end else begin
                     state_q      <= ST_DONE;
                     done_q       <= 1'b1;
                     alu_out_q    <= res_d;
                     alu_out_hi_q <= '0;
                     flags_q      <= flags_d;
                     if (op == OP_HLT) begin
                        halted_q <= 1'b1;
                     end
                  end
               end
            end
            ST_MUL: begin
               if (mul_last) begin
                  state_q      <= ST_DONE;
                  done_q       <= 1'b1;
                  alu_out_q    <= mul_nxt[MSB:0];
                  alu_out_hi_q <= mul_nxt[2*WIDTH-1:WIDTH];
                  flags_q      <= mul_flags_d;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy       = (state_q != ST_IDLE);
   assign done       = done_q;
   assign alu_out    = alu_out_q;
   assign alu_out_hi = alu_out_hi_q;
   assign flags      = flags_q;
   assign halted     = halted_q;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
// Scoreboard bench for alu_seq. Two instances (WIDTH=8 and WIDTH=16) share
// clock and reset. The stimulus side predicts each accepted operation with an
// arithmetic reference model and queues the expected outputs together with the
// cycle in which done must appear; per-instance monitors pop and compare on
// every done pulse.
// -----------------------------------------------------------------------------
module tb_alu_seq;
   import alu_pkg::*;

   typedef struct packed {
      logic [15:0] out;
      logic [15:0] hi;
      logic [3:0]  flags;
      logic        halted;
      logic [31:0] cyc;
   } exp_t;

   logic        clk;
   logic        rst_n;

   logic        s8, pc8, busy8, done8, halt8;
   logic [3:0]  op8, fl8;
   logic [7:0]  a8, b8, out8, hi8;

   logic        s16, pc16, busy16, done16, halt16;
   logic [3:0]  op16, fl16;
   logic [15:0] a16, b16, out16, hi16;

   int          cyc;
   int          n_tests;
   int          n_fail;
   exp_t        q8[$];
   exp_t        q16[$];
   bit          halted_m[2];
   exp_t        last_m[2];
   exp_t        e8, e16;

   alu_seq #(.WIDTH(8), .OPW(4)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(s8), .op(op8), .accum(a8), .alu_in(b8),
      .pc_in(pc8), .busy(busy8), .done(done8), .alu_out(out8), .alu_out_hi(hi8),
      .flags(fl8), .halted(halt8)
   );

   alu_seq #(.WIDTH(16), .OPW(4)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(s16), .op(op16), .accum(a16), .alu_in(b16),
      .pc_in(pc16), .busy(busy16), .done(done16), .alu_out(out16), .alu_out_hi(hi16),
      .flags(fl16), .halted(halt16)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: plain integer arithmetic on w-bit unsigned values.
   function automatic longint sgn(input longint x, input int w);
      return (x >= (longint'(1) << (w - 1))) ? x - (longint'(1) << w) : x;
   endfunction

   function automatic exp_t model(input int w, input logic [3:0] op, input longint a,
                                  input longint b, input bit pc, input bit halted_in);
      exp_t   e;
      longint m, lim, r, hi, bb, s;
      bit     c, v, z, n;
      m   = (longint'(1) << w) - 1;
      lim = longint'(1) << (w - 1);
      r = a; hi = 0; c = 0; v = 0;
      case (op)
         OP_NOP:                         r = pc ? b : a;
         OP_LDO, OP_LDA, OP_PRE, OP_JMP: r = b;
         OP_CLR:                         r = 0;
         OP_ADD, OP_ADN, OP_INC: begin
            bb = (op == OP_ADD) ? b : (op == OP_ADN) ? (b % (longint'(1) << (w / 2))) : 1;
            r  = (a + bb) & m;
            c  = (a + bb) > m;
            s  = sgn(a, w) + sgn(bb, w);
            v  = (s >= lim) || (s < -lim);
         end
         OP_SUB, OP_DEC, OP_CMP: begin
            bb = (op == OP_DEC) ? 1 : b;
            r  = (a - bb) & m;
            c  = a < bb;
            s  = sgn(a, w) - sgn(bb, w);
            v  = (s >= lim) || (s < -lim);
         end
         OP_MUL: begin
            r  = (a * b) & m;
            hi = (a * b) >> w;
            c  = hi != 0;
         end
         default:                        r = a;
      endcase
      z = (r == 0);
      n = ((r >> (w - 1)) & 1) != 0;
      if (op == OP_CMP) begin
         z = (a == b);
         r = a;
      end
      e.out    = 16'(r);
      e.hi     = 16'(hi);
      e.flags  = {z, n, c, v};
      e.halted = halted_in || (op == OP_HLT);
      e.cyc    = '0;
      return e;
   endfunction

   task automatic drive(input int d, input bit st, input logic [3:0] op,
                        input logic [15:0] a, input logic [15:0] b, input bit pc);
      if (d == 0) begin
         s8 = st; op8 = op; a8 = a[7:0]; b8 = b[7:0]; pc8 = pc;
      end else begin
         s16 = st; op16 = op; a16 = a; b16 = b; pc16 = pc;
      end
   endtask

   // Issue one request to instance d. When poke is set, start stays high with
   // random op/operands for every cycle until done, all of which must be ignored.
   task automatic issue(input int d, input logic [3:0] op, input logic [15:0] a_in,
                        input logic [15:0] b_in, input bit pc, input bit poke);
      int          w, lat;
      exp_t        e;
      logic [15:0] a, b;
      w = (d == 0) ? 8 : 16;
      a = a_in; b = b_in;
      if (w == 8) begin
         a[15:8] = '0; b[15:8] = '0;
      end
      lat = (op == OP_MUL) ? w + 1 : 1;
      @(negedge clk);
      s8 = 1'b0; s16 = 1'b0;
      check((d == 0) ? "busy_at_issue8" : "busy_at_issue16",
            32'((d == 0) ? busy8 : busy16), 32'd0);
      drive(d, 1'b1, op, a, b, pc);
      if (!halted_m[d]) begin
         e        = model(w, op, longint'(a), longint'(b), pc, halted_m[d]);
         e.cyc    = 32'(cyc + lat);
         halted_m[d] = e.halted;
         last_m[d]   = e;
         if (d == 0) q8.push_back(e);
         else        q16.push_back(e);
      end
      for (int i = 0; i < lat; i++) begin
         @(negedge clk);
         if (poke) drive(d, 1'b1, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 1'($urandom));
         else      drive(d, 1'b0, op, a, b, pc);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         s8 = 1'b0; s16 = 1'b0;
      end
   endtask

   task automatic check_regs(input int d, input exp_t e, input string tag);
      if (d == 0) begin
         check({tag, "_out8"},    32'(out8),  32'(e.out));
         check({tag, "_hi8"},     32'(hi8),   32'(e.hi));
         check({tag, "_flags8"},  32'(fl8),   32'(e.flags));
         check({tag, "_halted8"}, 32'(halt8), 32'(e.halted));
         check({tag, "_busy8"},   32'(busy8), 32'd0);
         check({tag, "_done8"},   32'(done8), 32'd0);
      end else begin
         check({tag, "_out16"},    32'(out16),  32'(e.out));
         check({tag, "_hi16"},     32'(hi16),   32'(e.hi));
         check({tag, "_flags16"},  32'(fl16),   32'(e.flags));
         check({tag, "_halted16"}, 32'(halt16), 32'(e.halted));
         check({tag, "_busy16"},   32'(busy16), 32'd0);
         check({tag, "_done16"},   32'(done16), 32'd0);
      end
   endtask

   // Start MUL on both instances, then pull reset in the 4th cycle of the
   // multiply; outputs must clear at once and no done may follow.
   task automatic reset_mid_mul();
      exp_t zero;
      zero = '0;
      @(negedge clk);
      drive(0, 1'b1, OP_MUL, 16'($urandom), 16'($urandom), 1'b0);
      drive(1, 1'b1, OP_MUL, 16'($urandom), 16'($urandom), 1'b0);
      @(negedge clk);
      s8 = 1'b0; s16 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_regs(0, zero, "rst_mid_mul");
      check_regs(1, zero, "rst_mid_mul");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      halted_m[0] = 1'b0;
      halted_m[1] = 1'b0;
   endtask

   // Scoreboard monitors
   always @(negedge clk) begin
      if (rst_n && done8) begin
         if (q8.size() == 0) begin
            check("unexpected_done8", 32'd1, 32'd0);
         end else begin
            e8 = q8.pop_front();
            check("done_cycle8", 32'(cyc),   e8.cyc);
            check("out8",        32'(out8),  32'(e8.out));
            check("hi8",         32'(hi8),   32'(e8.hi));
            check("flags8",      32'(fl8),   32'(e8.flags));
            check("halted8",     32'(halt8), 32'(e8.halted));
            check("busy_done8",  32'(busy8), 32'd1);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && done16) begin
         if (q16.size() == 0) begin
            check("unexpected_done16", 32'd1, 32'd0);
         end else begin
            e16 = q16.pop_front();
            check("done_cycle16", 32'(cyc),    e16.cyc);
            check("out16",        32'(out16),  32'(e16.out));
            check("hi16",         32'(hi16),   32'(e16.hi));
            check("flags16",      32'(fl16),   32'(e16.flags));
            check("halted16",     32'(halt16), 32'(e16.halted));
            check("busy_done16",  32'(busy16), 32'd1);
         end
      end
   end

   initial begin
      exp_t zero;
      int   d;
      zero    = '0;
      n_tests = 0;
      n_fail  = 0;
      cyc     = 0;
      rst_n   = 1'b0;
      drive(0, 1'b0, OP_NOP, 16'h0, 16'h0, 1'b0);
      drive(1, 1'b0, OP_NOP, 16'h0, 16'h0, 1'b0);
      halted_m[0] = 1'b0;
      halted_m[1] = 1'b0;

      repeat (3) @(negedge clk);
      check_regs(0, zero, "reset");
      check_regs(1, zero, "reset");
      rst_n = 1'b1;
      idle(2);

      // Directed cases, WIDTH=8
      issue(0, OP_ADD, 16'hF0, 16'h20, 1'b0, 1'b0);
      issue(0, OP_SUB, 16'h05, 16'h07, 1'b0, 1'b0);
      issue(0, OP_CMP, 16'h3C, 16'h3C, 1'b0, 1'b0);
      issue(0, OP_MUL, 16'hFF, 16'hFF, 1'b0, 1'b1);
      issue(0, OP_ADN, 16'h7E, 16'hF3, 1'b0, 1'b0);
      issue(0, OP_INC, 16'hFF, 16'h00, 1'b0, 1'b0);
      issue(0, OP_DEC, 16'h00, 16'h00, 1'b0, 1'b0);
      issue(0, OP_CLR, 16'h5A, 16'h33, 1'b0, 1'b0);
      issue(0, OP_CMP, 16'h10, 16'h80, 1'b0, 1'b0);

      // Directed cases, WIDTH=16
      issue(1, OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
      issue(1, OP_ADD, 16'h8000, 16'h8000, 1'b0, 1'b0);
      issue(1, OP_SUB, 16'h0000, 16'h0001, 1'b0, 1'b0);
      issue(1, OP_ADN, 16'h7FFF, 16'hFF01, 1'b0, 1'b0);

      // Random traffic on both widths (HLT excluded so the run keeps going)
      for (int k = 0; k < 80; k++) begin
         d = $urandom_range(0, 1);
         issue(d, 4'($urandom_range(0, 14)), 16'($urandom), 16'($urandom),
               1'($urandom), ($urandom_range(0, 3) == 0));
      end
      idle(2);

      // Halt, then a start that must be ignored with outputs held
      issue(0, OP_HLT, 16'h42, 16'($urandom), 1'b0, 1'b0);
      issue(0, OP_ADD, 16'h01, 16'h02, 1'b0, 1'b0);
      idle(4);
      check_regs(0, last_m[0], "held_after_hlt");

      // Reset in the middle of a multiply, once with DUT8 halted, once without
      reset_mid_mul();
      idle(2);
      reset_mid_mul();
      idle(2);

      // NOP selecting B after reset
      issue(0, OP_NOP, 16'h3C, 16'h00A5, 1'b1, 1'b0);
      issue(1, OP_NOP, 16'h3C3C, 16'h00A5, 1'b1, 1'b0);
      issue(0, OP_NOP, 16'h3C, 16'h00A5, 1'b0, 1'b0);
      idle(4);

      check("pending8",  32'(q8.size()),  32'd0);
      check("pending16", 32'(q16.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
